// File: rtl/md_unit.sv
// md_unit: multi-cycle RV32M multiply/divide unit for the execute stage.
// Radix-2 iterative datapath: shift-add multiply and restoring divide on
// operand magnitudes, with sign correction applied when the result is loaded.
// Optional feature macro: MD_FAST_SPECIAL_EN -- when defined, divide-by-zero,
// signed divide overflow and multiply-by-zero skip the iterations and complete
// in the cycle after the start edge.
`timescale 1ns/1ps

module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic [2:0]       i_md_op,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_md_data
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg;
    logic [2:0]       op_reg;
    logic             sign_a_reg;
    logic             neg_reg;
    logic             div_zero_reg;
    logic             ovf_reg;
    logic [WIDTH-1:0] oper_reg;     // multiplicand (mul) or divisor magnitude (div)
    logic [WIDTH-1:0] acc_hi_reg;   // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo_reg;   // multiplier->product low half / dividend->quotient
    logic [CW-1:0]    count_reg;
    logic             busy_reg;
    logic             valid_reg;
    logic [WIDTH-1:0] result_reg;

    // Operand decode at the start edge: signedness, magnitudes, special cases
    logic             is_div_in;
    logic             signed_a_in;
    logic             signed_b_in;
    logic             sign_a_in;
    logic             sign_b_in;
    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;
    logic             div_zero_in;
    logic             ovf_in;

    // Decode funct3 into signedness and special-case flags for the incoming request
    always_comb begin
        is_div_in   = i_md_op[2];
        // MUL/MULH/MULHSU treat rs1 as signed; DIV/REM treat both as signed
        signed_a_in = is_div_in ? ~i_md_op[0] : (i_md_op[1:0] != 2'b11);
        signed_b_in = is_div_in ? ~i_md_op[0] : ~i_md_op[1];
        sign_a_in   = signed_a_in & i_op_a[WIDTH-1];
        sign_b_in   = signed_b_in & i_op_b[WIDTH-1];
        a_mag_in    = sign_a_in ? (-i_op_a) : i_op_a;
        b_mag_in    = sign_b_in ? (-i_op_b) : i_op_b;
        div_zero_in = is_div_in & (i_op_b == '0);
        ovf_in      = is_div_in & ~i_md_op[0] & (i_op_a == MOST_NEG) & (i_op_b == ALL_ONES);
    end

`ifdef MD_FAST_SPECIAL_EN
    logic             fast_hit_in;
    logic [WIDTH-1:0] fast_result_in;

    // Short-circuit results that are known without iterating
    always_comb begin
        fast_hit_in    = div_zero_in | ovf_in |
                         (~is_div_in & ((i_op_a == '0) | (i_op_b == '0)));
        fast_result_in = '0;
        if (div_zero_in)
            fast_result_in = i_md_op[1] ? i_op_a : ALL_ONES;
        else if (ovf_in)
            fast_result_in = i_md_op[1] ? '0 : i_op_a;
    end
`endif

    // One radix-2 iteration and the sign-corrected result it would produce
    logic [WIDTH-1:0]   acc_hi_next;
    logic [WIDTH-1:0]   acc_lo_next;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_signed;
    logic [WIDTH-1:0]   final_result;

    // Datapath step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        acc_hi_next = acc_hi_reg;
        acc_lo_next = acc_lo_reg;
        sum         = '0;
        shifted     = '0;
        diff        = '0;
        if (op_reg[2]) begin
            shifted = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
            diff    = {1'b0, shifted} - {2'b00, oper_reg};
            if (!diff[WIDTH+1]) begin
                acc_hi_next = diff[WIDTH-1:0];
                acc_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_next = shifted[WIDTH-1:0];
                acc_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, oper_reg} : {(WIDTH+1){1'b0}});
            {acc_hi_next, acc_lo_next} = {sum, acc_lo_reg[WIDTH-1:1]};
        end
    end

    // Result selection with sign correction and forced special cases
    always_comb begin
        prod        = {acc_hi_next, acc_lo_next};
        prod_signed = neg_reg ? (-prod) : prod;
        quo_signed  = neg_reg ? (-acc_lo_next) : acc_lo_next;
        rem_signed  = sign_a_reg ? (-acc_hi_next) : acc_hi_next;
        case (op_reg)
            3'b000:  final_result = prod_signed[WIDTH-1:0];
            3'b001,
            3'b010,
            3'b011:  final_result = prod_signed[2*WIDTH-1:WIDTH];
            default: final_result = op_reg[1] ? rem_signed : quo_signed;
        endcase
        // A zero divisor leaves the dividend magnitude in the remainder, so
        // the sign-corrected remainder is already the dividend; only the
        // quotient needs forcing.
        if (div_zero_reg && !op_reg[1])
            final_result = ALL_ONES;
        else if (ovf_reg)
            final_result = op_reg[1] ? '0 : MOST_NEG;
    end

    // Control FSM with registered busy/valid/result
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            valid_reg    <= 1'b0;
            result_reg   <= '0;
            count_reg    <= '0;
            op_reg       <= '0;
            sign_a_reg   <= 1'b0;
            neg_reg      <= 1'b0;
            div_zero_reg <= 1'b0;
            ovf_reg      <= 1'b0;
            oper_reg     <= '0;
            acc_hi_reg   <= '0;
            acc_lo_reg   <= '0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        op_reg       <= i_md_op;
                        sign_a_reg   <= sign_a_in;
                        neg_reg      <= sign_a_in ^ sign_b_in;
                        div_zero_reg <= div_zero_in;
                        ovf_reg      <= ovf_in;
                        oper_reg     <= is_div_in ? b_mag_in : a_mag_in;
                        acc_hi_reg   <= '0;
                        acc_lo_reg   <= is_div_in ? a_mag_in : b_mag_in;
                        count_reg    <= '0;
                        busy_reg     <= 1'b1;
`ifdef MD_FAST_SPECIAL_EN
                        if (fast_hit_in) begin
                            state_reg  <= DONE;
                            valid_reg  <= 1'b1;
                            result_reg <= fast_result_in;
                        end else begin
                            state_reg <= CALC;
                        end
`else
                        state_reg <= CALC;
`endif
                    end
                end
                CALC: begin
                    acc_hi_reg <= acc_hi_next;
                    acc_lo_reg <= acc_lo_next;
                    count_reg  <= count_reg + CW'(1);
                    if (count_reg == LAST_COUNT) begin
                        state_reg  <= DONE;
                        valid_reg  <= 1'b1;
                        result_reg <= final_result;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_busy    = busy_reg;
    assign o_valid   = valid_reg;
    assign o_md_data = result_reg;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed-vector bench for md_unit (result, latency, pulse
// width, busy window, ignored restart, reset abort).
`timescale 1ns/1ps

module tb_md_unit;

    logic        clk;
    logic        i_reset;
    logic        i_start;
    logic [31:0] i_op_a;
    logic [31:0] i_op_b;
    logic [2:0]  i_md_op;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_md_data;

    int checks = 0;
    int errors = 0;

    md_unit #(.WIDTH(32)) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_start   (i_start),
        .i_op_a    (i_op_a),
        .i_op_b    (i_op_b),
        .i_md_op   (i_md_op),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .o_md_data (o_md_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called right after a negedge. Cycle n is sampled at the n-th negedge
    // after the start edge. disturb: restart with other operands in cycle 5.
    // reset_at: assert reset in that cycle and check the aborted state.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit special,
                          input bit disturb, input int reset_at);
        int lat;
        int first;
        int pulses;
        int busy_bad;
        logic [31:0] data;
        lat = 33;
`ifdef MD_FAST_SPECIAL_EN
        if (special) lat = 1;
`else
        if (special) lat = 33;
`endif
        first = 0;
        pulses = 0;
        busy_bad = 0;
        data = 32'h0;
        i_md_op = op;
        i_op_a  = a;
        i_op_b  = b;
        i_start = 1'b1;
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge clk);
            if (n == 1) i_start = 1'b0;
            if (o_valid) begin
                pulses++;
                if (first == 0) first = n;
                data = o_md_data;
            end
            if (o_busy !== (n <= lat)) busy_bad++;
            if (disturb && n == 5) begin
                i_start = 1'b1;
                i_op_a  = ~a;
                i_op_b  = 32'd3;
                i_md_op = 3'b000;
            end
            if (disturb && n == 6) i_start = 1'b0;
            if (reset_at != 0 && n == reset_at) begin
                i_reset = 1'b1;
                @(negedge clk);
                check({name, " rst busy"},  {31'b0, o_busy},  32'd0);
                check({name, " rst valid"}, {31'b0, o_valid}, 32'd0);
                check({name, " rst data"},  o_md_data,        32'd0);
                check({name, " rst pulses"}, pulses,          32'd0);
                $display("%s a=%h b=%h aborted by reset in cycle %0d", name, a, b, n);
                i_reset = 1'b0;
                return;
            end
        end
        $display("%s a=%h b=%h -> %h valid cycle %0d pulses %0d", name, a, b, data, first, pulses);
        check({name, " data"},    data,     exp);
        check({name, " latency"}, first,    lat);
        check({name, " pulses"},  pulses,   32'd1);
        check({name, " busy"},    busy_bad, 32'd0);
    endtask

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_op_a  = 32'h0;
        i_op_b  = 32'h0;
        i_md_op = 3'b000;
        repeat (3) @(negedge clk);
        check("reset busy",  {31'b0, o_busy},  32'd0);
        check("reset valid", {31'b0, o_valid}, 32'd0);
        check("reset data",  o_md_data,        32'd0);
        i_reset = 1'b0;
        @(negedge clk);

        run_op("MUL",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0, 0);
        run_op("MULH",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0, 0);
        run_op("MULHU",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 0);
        run_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
        run_op("DIV",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0, 0);
        run_op("REM",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0, 0);
        run_op("DIVU",   3'b101, 32'd100,      32'd7,        32'd14,       1'b0, 1'b1, 0);
        run_op("REMU",   3'b111, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 0);
        run_op("DIVU-rst", 3'b101, 32'd1000,   32'd3,        32'd333,      1'b0, 1'b1, 10);
        run_op("DIVU-post", 3'b101, 32'd9,     32'd4,        32'd2,        1'b0, 1'b0, 0);
        run_op("DIV0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0, 0);
        run_op("REMU0",  3'b111, 32'd5,        32'd0,        32'd5,        1'b1, 1'b0, 0);
        run_op("REM0",   3'b110, 32'hFFFFFFEC, 32'd0,        32'hFFFFFFEC, 1'b1, 1'b0, 0);
        run_op("DIVU0",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0, 0);
        run_op("DIVOVF", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 0);
        run_op("REMOVF", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 0);
        run_op("MULZ",   3'b000, 32'd0,        32'd5,        32'd0,        1'b1, 1'b0, 0);
        run_op("MULHN",  3'b001, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle RV32M multiply/divide unit; runs beside the single-cycle integer ALU in the execute stage.
- Takes the same 32-bit operand pair plus a 3-bit funct3 op select, and runs a start/busy/valid handshake with the core control.
- Radix-2 iterative datapath: shift-add multiply, restoring divide on magnitudes, with sign correction at completion.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  request; sampled only in IDLE.
- i_op_a  input  WIDTH  multiplicand/dividend (rs1).
- i_op_b  input  WIDTH  multiplier/divisor (rs2).
- i_md_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- o_busy  output  1  high whenever state is not IDLE.
- o_valid  output  1  one-cycle completion pulse.
- o_md_data  output  WIDTH  result.

Behaviour:
- Clock and reset: one clock (i_clk); reset (i_reset) is synchronous and active-high.
- Reset values: state IDLE, o_busy 0, o_valid 0, o_md_data 0, counter 0.
- Reset mid-operation aborts immediately with no result pulse.
- States:
  - IDLE: i_start=1 at an edge latches i_op_a, i_op_b and i_md_op, computes magnitudes and sign flags, clears the accumulator, sets counter 0, and goes to CALC. Operands are not sampled again after this edge.
  - CALC: one iteration per edge, counter+1. The edge with counter==WIDTH-1 goes to DONE and loads the sign-corrected result into o_md_data.
  - DONE: o_valid=1 for exactly one cycle; the next edge goes to IDLE.
- Latency: o_valid is high in the cycle after the WIDTH-th CALC edge, i.e. WIDTH+1 cycles after the start edge (33 for WIDTH=32).
- Back-to-back: a new start is accepted in the cycle after DONE, when state is IDLE.
- i_start outside IDLE is ignored; no queueing.
- o_md_data holds its value until the next result is loaded.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Multiply:
  - Unsigned WIDTH x WIDTH product, 2*WIDTH-bit accumulator.
  - Negated if sign_a^sign_b.
  - MUL returns the low half; MULH* return the high half.
- Divide:
  - Restoring divide on magnitudes.
  - Quotient negated if sign_a^sign_b; remainder takes sign_a.
- Special cases (RISC-V spec):
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give the dividend.
  - Signed overflow (a=most-negative, b=-1): DIV gives a; REM gives 0.
  - Without the optional feature, these special cases still take the full WIDTH iterations; the result is forced at the DONE load.
- All arithmetic is modulo 2^WIDTH; no flags are output.

Optional Feature:
- Macro MD_FAST_SPECIAL_EN.
- Defined: in IDLE, a start with divisor 0, signed overflow, or either multiply operand 0 goes directly to DONE with the final result loaded. o_valid then appears 1 cycle after the start edge; o_busy is high for that DONE cycle only.
- Undefined: every operation takes the full WIDTH+1 cycle latency. Results are identical in both builds.

Test Plan:
- MUL 7 x 0xFFFFFFFD -> o_md_data 0xFFFFFFEB, o_valid on cycle 33 after the start edge, single pulse, o_busy high cycles 1-33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Start DIVU, pulse i_start again and change operands at cycle 5 (ignored), assert i_reset at cycle 10 -> next cycle o_busy 0, o_valid 0, o_md_data 0, no o_valid pulse afterwards. A new start in the following cycle completes normally.
- With MD_FAST_SPECIAL_EN: DIV 5/0 -> o_valid the cycle after the start edge with 0xFFFFFFFF. Without the macro -> same value at cycle 33.
